// File: rtl/muldiv_sequencer.sv
// Sequencer for the M-extension multiply/divide units in EX.
// It latches operands, starts the right unit and stalls the pipe while the unit is busy.
// Divide-by-zero and signed-overflow divides are answered in the same cycle without a unit.
// A busy operation ends on unit completion, on kill, or on timeout.
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [31:0] mul_result,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        mul_start,
    output logic        div_start,
    output logic        unit_abort,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [2:0]  op_funct3,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] busyCnt;
    logic [XLEN-1:0]  resultReg;

    logic             divByZero;
    logic             divOverflow;
    logic             shortcut;
    logic [XLEN-1:0]  shortcutValue;
    logic             unitDone;
    logic             timedOut;

    logic             latchOps;
    logic             loadResult;
    logic [XLEN-1:0]  resultNext;
    logic             setTimeout;

    // Shortcut detection and the architecturally defined result for those cases
    always_comb begin
        divByZero     = (b == '0);
        divOverflow   = ~funct3[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        shortcut      = funct3[2] & (divByZero | divOverflow);
        shortcutValue = '0;
        if (funct3[1]) begin
            shortcutValue = divByZero ? a : '0;
        end else begin
            shortcutValue = divByZero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
        unitDone = ((state == MUL) & mul_done) | ((state == DIV) & div_done);
        timedOut = (busyCnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: kill beats done, done beats timeout
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req_valid & ~kill & ~shortcut) begin
                    stateNext = funct3[2] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (kill) begin
                    stateNext = IDLE;
                end else if (unitDone | timedOut) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output and datapath-control decode; everything is held at zero while reset is high
    always_comb begin
        mul_start    = 1'b0;
        div_start    = 1'b0;
        unit_abort   = 1'b0;
        stall        = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        latchOps     = 1'b0;
        loadResult   = 1'b0;
        resultNext   = '0;
        setTimeout   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req_valid & ~kill) begin
                        if (shortcut) begin
                            result       = shortcutValue;
                            result_valid = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            latchOps  = 1'b1;
                            mul_start = ~funct3[2];
                            div_start = funct3[2];
                        end
                    end
                end
                MUL, DIV: begin
                    stall = 1'b1;
                    if (kill) begin
                        unit_abort = 1'b1;
                    end else if (unitDone) begin
                        loadResult = 1'b1;
                        if (state == MUL) begin
                            resultNext = mul_result;
                        end else begin
                            resultNext = op_funct3[1] ? div_rem : div_quot;
                        end
                    end else if (timedOut) begin
                        unit_abort = 1'b1;
                        setTimeout = 1'b1;
                        loadResult = 1'b1;
                        resultNext = '0;
                    end
                end
                DONE: begin
                    if (!kill) begin
                        result       = resultReg;
                        result_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand latches, busy counter, result register and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_funct3   <= '0;
            busyCnt     <= '0;
            resultReg   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (latchOps) begin
                op_a      <= a;
                op_b      <= b;
                op_funct3 <= funct3;
            end
            if (latchOps) begin
                busyCnt <= '0;
            end else if ((state == MUL) || (state == DIV)) begin
                busyCnt <= busyCnt + CNT_W'(1);
            end
            if (loadResult) begin
                resultReg <= resultNext;
            end
            if (setTimeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: the bench plays both arithmetic units and
// checks the sequencer against a plain-arithmetic RISC-V M reference.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        mul_done;
    logic        div_done;
    logic [31:0] mul_result;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        mul_start;
    logic        div_start;
    logic        unit_abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_funct3;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        timeout_err;

    int nChecks = 0;
    int nFail   = 0;

    // observations collected by runOp
    logic [31:0] obsRes;
    int          obsValid, obsStall, obsMulStart, obsDivStart, obsAbort, obsValidK, obsAbortK;
    bit          obsOpsOk;

    muldiv_sequencer #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .funct3(funct3),
        .a(a), .b(b), .kill(kill), .mul_done(mul_done), .div_done(div_done),
        .mul_result(mul_result), .div_quot(div_quot), .div_rem(div_rem),
        .mul_start(mul_start), .div_start(div_start), .unit_abort(unit_abort),
        .op_a(op_a), .op_b(op_b), .op_funct3(op_funct3), .stall(stall),
        .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension result computed directly from the ISA definition
    function automatic logic [31:0] refOp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        p  = '0;
        case (f)
            3'b000, 3'b011: p = {32'b0, x} * {32'b0, y};
            3'b001:         p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            3'b010:         p = {{32{x[31]}}, x} * {32'b0, y};
            default: ;
        endcase
        if (f == 3'b000) return p[31:0];
        if (!f[2]) return p[63:32];
        if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
        if (f == 3'b100) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sx / sy);
        end
        if (f == 3'b110) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sx % sy);
        end
        if (f == 3'b101) return x / y;
        return x % y;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; kill = 1'b0; mul_done = 1'b0; div_done = 1'b0;
        end
    endtask

    // Present one instruction in EX until the sequencer reports a result (bounded),
    // acting as the arithmetic units; done arrives lat cycles after the start cycle.
    task automatic runOp(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input bit noise);
        bit finished;
        bit rnd;
        finished = 1'b0;
        obsRes = '0; obsValid = 0; obsStall = 0; obsMulStart = 0; obsDivStart = 0;
        obsAbort = 0; obsValidK = -1; obsAbortK = -1; obsOpsOk = 1'b1;
        for (int k = 0; k < 30 && !finished; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; kill = 1'b0; funct3 = f;
            a = (k == 0) ? av : $urandom;
            b = (k == 0) ? bv : $urandom;
            rnd = noise && ($urandom_range(0, 1) == 1);
            mul_result = f[2] ? $urandom : refOp(f, av, bv);
            div_quot   = refOp({2'b10, f[0]}, av, bv);
            div_rem    = refOp({2'b11, f[0]}, av, bv);
            mul_done   = f[2] ? rnd : ((k == lat) || (rnd && (k == 0 || k > lat)));
            div_done   = f[2] ? ((k == lat) || (rnd && (k == 0 || k > lat))) : rnd;
            #1;
            if (stall) obsStall++;
            if (mul_start) obsMulStart++;
            if (div_start) obsDivStart++;
            if (unit_abort) begin obsAbort++; obsAbortK = k; end
            if (k >= 1 && stall && (op_a !== av || op_b !== bv || op_funct3 !== f)) obsOpsOk = 1'b0;
            if (result_valid) begin obsValid++; obsRes = result; obsValidK = k; finished = 1'b1; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b1; funct3 = 3'b000; a = 32'd7; b = 32'd6;
        kill = 1'b0; mul_done = 1'b0; div_done = 1'b0;
        mul_result = '0; div_quot = '0; div_rem = '0;
        #2;
        nChecks++; if (mul_start !== 1'b0) begin nFail++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL reset_stall: got %b want 0", stall); end
        nChecks++; if (result_valid !== 1'b0 || result !== 32'd0) begin nFail++; $display("FAIL reset_result: got %b/%h want 0/0", result_valid, result); end
        nChecks++; if (op_a !== 32'd0 || op_b !== 32'd0 || op_funct3 !== 3'd0) begin nFail++; $display("FAIL reset_ops: got %h %h %h want 0", op_a, op_b, op_funct3); end
        nChecks++; if (timeout_err !== 1'b0 || unit_abort !== 1'b0) begin nFail++; $display("FAIL reset_flags: got %b %b want 0 0", timeout_err, unit_abort); end
        @(posedge clk); @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0;
        #1;
        nChecks++; if (mul_start !== 1'b0 || div_start !== 1'b0 || stall !== 1'b0) begin nFail++; $display("FAIL post_reset_idle: got start %b%b stall %b want 0", mul_start, div_start, stall); end
        idle(1);
    endtask

    task automatic test_mul;
        runOp(3'b000, 32'd7, 32'd6, 3, 1'b0);
        nChecks++; if (obsRes !== 32'd42) begin nFail++; $display("FAIL mul_result: got %h want %h", obsRes, 32'd42); end
        nChecks++; if (obsValid !== 1 || obsValidK !== 4) begin nFail++; $display("FAIL mul_valid: got %0d at cycle %0d want 1 at cycle 4", obsValid, obsValidK); end
        nChecks++; if (obsStall !== 4) begin nFail++; $display("FAIL mul_stall_cycles: got %0d want 4", obsStall); end
        nChecks++; if (obsMulStart !== 1 || obsDivStart !== 0) begin nFail++; $display("FAIL mul_starts: got mul %0d div %0d want 1 0", obsMulStart, obsDivStart); end
        nChecks++; if (!obsOpsOk) begin nFail++; $display("FAIL mul_ops_stable: got changed want held"); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        runOp(3'b100, 32'hFFFF_FFEC, 32'd3, 2, 1'b0);
        nChecks++; if (obsRes !== 32'hFFFF_FFFA) begin nFail++; $display("FAIL div_result: got %h want FFFFFFFA", obsRes); end
        nChecks++; if (obsDivStart !== 1 || obsStall !== 3) begin nFail++; $display("FAIL div_shape: got starts %0d stall %0d want 1 3", obsDivStart, obsStall); end
        runOp(3'b110, 32'hFFFF_FFEC, 32'd3, 4, 1'b0);
        nChecks++; if (obsRes !== 32'hFFFF_FFFE) begin nFail++; $display("FAIL rem_result: got %h want FFFFFFFE", obsRes); end
        nChecks++; if (obsDivStart !== 1 || obsStall !== 5 || obsValidK !== 5) begin nFail++; $display("FAIL rem_shape: got starts %0d stall %0d validk %0d want 1 5 5", obsDivStart, obsStall, obsValidK); end
        idle(1);
    endtask

    task automatic test_shortcut;
        logic [2:0]  tf [5] = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b100};
        logic [31:0] ta [5] = '{32'd5, 32'h8000_0000, 32'h1234_5678, 32'hCAFE_F00D, 32'h8000_0000};
        logic [31:0] tb [5] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] te [5] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            runOp(tf[i], ta[i], tb[i], 3, 1'b0);
            nChecks++; if (obsRes !== te[i]) begin nFail++; $display("FAIL shortcut_result[%0d]: got %h want %h", i, obsRes, te[i]); end
            nChecks++; if (obsValidK !== 0 || obsStall !== 0 || obsDivStart !== 0 || obsMulStart !== 0) begin nFail++; $display("FAIL shortcut_shape[%0d]: got validk %0d stall %0d starts %0d want 0 0 0", i, obsValidK, obsStall, obsDivStart + obsMulStart); end
        end
        idle(1);
    endtask

    task automatic test_kill;
        int aborts, valids, starts, abortK;
        aborts = 0; valids = 0; starts = 0; abortK = -1;
        // kill after two full DIV cycles
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 4); kill = (k == 3); funct3 = 3'b100; a = 32'd100; b = 32'd7;
            mul_done = 1'b0; div_done = 1'b0;
            #1;
            if (unit_abort) begin aborts++; abortK = k; end
            if (result_valid) valids++;
            if (div_start) starts++;
            if (k == 4) begin
                nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL kill_stall_drop: got %b want 0", stall); end
            end
        end
        nChecks++; if (aborts !== 1 || abortK !== 3) begin nFail++; $display("FAIL kill_abort: got %0d at %0d want 1 at 3", aborts, abortK); end
        nChecks++; if (valids !== 0 || starts !== 1) begin nFail++; $display("FAIL kill_nores: got valids %0d starts %0d want 0 1", valids, starts); end
        // kill in IDLE suppresses the start
        @(posedge clk); #1; req_valid = 1'b1; kill = 1'b1; funct3 = 3'b000; #1;
        nChecks++; if (mul_start !== 1'b0 || stall !== 1'b0) begin nFail++; $display("FAIL kill_idle: got start %b stall %b want 0 0", mul_start, stall); end
        @(posedge clk); #1; req_valid = 1'b0; kill = 1'b0; #1;
        nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL kill_idle_stay: got stall %b want 0", stall); end
        // kill in DONE suppresses result_valid
        @(posedge clk); #1; req_valid = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clk); #1; mul_done = 1'b1; mul_result = 32'd12;
        @(posedge clk); #1; mul_done = 1'b0; kill = 1'b1; #1;
        nChecks++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL kill_done_valid: got %b want 0", result_valid); end
        @(posedge clk); #1; req_valid = 1'b0; kill = 1'b0; #1;
        nChecks++; if (stall !== 1'b0 || result_valid !== 1'b0) begin nFail++; $display("FAIL kill_done_idle: got stall %b valid %b want 0 0", stall, result_valid); end
        // kill coincident with done: kill wins
        @(posedge clk); #1; req_valid = 1'b1; funct3 = 3'b000;
        @(posedge clk); #1; mul_done = 1'b1; kill = 1'b1; #1;
        nChecks++; if (unit_abort !== 1'b1) begin nFail++; $display("FAIL kill_vs_done_abort: got %b want 1", unit_abort); end
        @(posedge clk); #1; mul_done = 1'b0; kill = 1'b0; req_valid = 1'b0; #1;
        nChecks++; if (result_valid !== 1'b0 || stall !== 1'b0) begin nFail++; $display("FAIL kill_vs_done_idle: got valid %b stall %b want 0 0", result_valid, stall); end
        idle(1);
    endtask

    task automatic test_done_beats_timeout;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        runOp(3'b001, x, y, 8, 1'b0);
        nChecks++; if (obsRes !== refOp(3'b001, x, y) || obsAbort !== 0) begin nFail++; $display("FAIL done_vs_timeout: got %h abort %0d want %h 0", obsRes, obsAbort, refOp(3'b001, x, y)); end
        nChecks++; if (timeout_err !== 1'b0 || obsStall !== 9) begin nFail++; $display("FAIL done_vs_timeout_flag: got err %b stall %0d want 0 9", timeout_err, obsStall); end
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] x, y, exp;
        int lat;
        bit isShort;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 20);
                default: ;
            endcase
            lat = $urandom_range(1, 7);
            isShort = f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
            exp = refOp(f, x, y);
            runOp(f, x, y, lat, 1'b1);
            nChecks++; if (obsRes !== exp || obsValid !== 1) begin nFail++; $display("FAIL rand_result[%0d] f=%b a=%h b=%h: got %h valid %0d want %h 1", i, f, x, y, obsRes, obsValid, exp); end
            nChecks++; if (obsStall !== (isShort ? 0 : lat + 1)) begin nFail++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, obsStall, isShort ? 0 : lat + 1); end
            nChecks++; if (obsMulStart !== ((!isShort && !f[2]) ? 1 : 0) || obsDivStart !== ((!isShort && f[2]) ? 1 : 0)) begin nFail++; $display("FAIL rand_starts[%0d]: got mul %0d div %0d", i, obsMulStart, obsDivStart); end
            nChecks++; if (obsAbort !== 0 || !obsOpsOk) begin nFail++; $display("FAIL rand_abort_ops[%0d]: got abort %0d opsok %b want 0 1", i, obsAbort, obsOpsOk); end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    task automatic test_timeout;
        runOp(3'b000, 32'd9, 32'd9, 100, 1'b0);
        nChecks++; if (obsAbort !== 1 || obsAbortK !== 8) begin nFail++; $display("FAIL timeout_abort: got %0d at %0d want 1 at 8", obsAbort, obsAbortK); end
        nChecks++; if (obsRes !== 32'd0 || obsValidK !== 9 || obsStall !== 9) begin nFail++; $display("FAIL timeout_done: got %h at %0d stall %0d want 0 at 9 stall 9", obsRes, obsValidK, obsStall); end
        nChecks++; if (timeout_err !== 1'b1) begin nFail++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
        runOp(3'b000, 32'd5, 32'd5, 2, 1'b0);
        nChecks++; if (timeout_err !== 1'b1 || obsRes !== 32'd25) begin nFail++; $display("FAIL timeout_sticky: got err %b res %h want 1 19", timeout_err, obsRes); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] x, y;
        x = $urandom | 32'd1; y = $urandom | 32'd1;
        @(posedge clk); #1; req_valid = 1'b1; funct3 = 3'b011; a = x; b = y;
        @(posedge clk); #3; reset = 1'b1; #1;
        nChecks++; if (stall !== 1'b0 || op_a !== 32'd0 || op_b !== 32'd0 || op_funct3 !== 3'd0) begin nFail++; $display("FAIL reset_mid_async: got stall %b ops %h %h %h want 0", stall, op_a, op_b, op_funct3); end
        nChecks++; if (timeout_err !== 1'b0 || result_valid !== 1'b0) begin nFail++; $display("FAIL reset_mid_flags: got err %b valid %b want 0 0", timeout_err, result_valid); end
        #1; req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #2;
        nChecks++; if (stall !== 1'b0 || mul_start !== 1'b0) begin nFail++; $display("FAIL reset_mid_idle: got stall %b start %b want 0 0", stall, mul_start); end
        runOp(3'b011, x, y, 1, 1'b0);
        nChecks++; if (obsRes !== refOp(3'b011, x, y) || obsStall !== 2) begin nFail++; $display("FAIL reset_mid_resume: got %h stall %0d want %h 2", obsRes, obsStall, refOp(3'b011, x, y)); end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_back_to_back;
        test_shortcut;
        test_kill;
        test_done_beats_timeout;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
